// File: rtl/row_dot_pkg.sv
// Shared definitions for row_dot_engine: default sizes, FSM states and the
// shift-and-convert helper. Build option: ROW_DOT_SAT_EN selects saturating
// output conversion; without it the scaled result wraps to 16 bits.
package row_dot_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int N_DEF     = 8;
  localparam int FRAC_DEF  = 8;
  localparam int ACC_W     = 35;   // 8 products of 32 bits never overflow 35 bits
  localparam int IDX_W     = 3;    // row / column index width for N = 8

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    MAC,
    OUT
  } state_t;

  // Arithmetic shift (floor) by frac, then reduce to a 16-bit result.
  function automatic logic [15:0] scale_out(input logic signed [ACC_W-1:0] acc,
                                            input int frac);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> frac;
`ifdef ROW_DOT_SAT_EN
    if (sh > ACC_W'(32767))
      return 16'h7fff;
    else if (sh < ACC_W'(-32768))
      return 16'h8000;
    else
      return sh[15:0];
`else
    return sh[15:0];
`endif
  endfunction

endpackage

// File: rtl/row_dot_engine_mac16.sv
// mac16: 16x16 signed multiply feeding a 35-bit accumulator with clear and
// enable. The next-accumulator value is exposed so the caller can register
// the final sum in the same cycle as the last product.
module mac16
  import row_dot_pkg::*;
#(
  parameter int W  = WIDTH_DEF,
  parameter int AW = ACC_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [W-1:0]         i_a,
  input  logic [W-1:0]         i_b,
  output logic signed [AW-1:0] o_acc_next
);

  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0]  r_acc;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign o_acc_next = r_acc + AW'(w_prod);

  // Accumulator: cleared before each row, advanced once per enabled cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_acc <= '0;
    else if (i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= o_acc_next;
  end

endmodule

// File: rtl/row_dot_engine.sv
// row_dot_engine: walks the 8 rows of the matrix RAM, forms the fixed-point
// dot product of each row with a latched coefficient vector and hands each
// scaled result out over valid/ready. Build option: ROW_DOT_SAT_EN
// (saturating output conversion, see row_dot_pkg::scale_out).
module row_dot_engine
  import row_dot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH*N-1:0] coef,
  output logic [IDX_W-1:0]   ri_address,
  input  logic [WIDTH*N-1:0] r_data,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]   out_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_t                  r_state, w_state_next;
  logic [IDX_W-1:0]        r_row, r_j, r_ri_address, r_out_row;
  logic [WIDTH*N-1:0]      r_coef, r_row_buf;
  logic [WIDTH-1:0]        r_out_data;
  logic                    r_out_valid, r_done;
  logic                    w_accept, w_handshake, w_mac_last;
  logic [WIDTH-1:0]        w_row_word  [N];
  logic [WIDTH-1:0]        w_coef_word [N];
  logic signed [ACC_W-1:0] w_acc_next;

  // Unpack the row buffer and coefficient vector into word arrays.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_row_word[gi]  = r_row_buf[gi*WIDTH +: WIDTH];
    assign w_coef_word[gi] = r_coef[gi*WIDTH +: WIDTH];
  end

  mac16 #(.W(WIDTH), .AW(ACC_W)) u_mac (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clr      (r_state == FETCH),
    .i_en       (r_state == MAC),
    .i_a        (w_row_word[r_j]),
    .i_b        (w_coef_word[r_j]),
    .o_acc_next (w_acc_next)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state decode plus the one-cycle control strobes used by the datapath.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_mac_last   = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept     = 1'b1;
        w_state_next = FETCH;
      end
      FETCH: w_state_next = MAC;
      MAC: if (r_j == IDX_W'(N - 1)) begin
        w_mac_last   = 1'b1;
        w_state_next = OUT;
      end
      OUT: if (out_ready) begin
        w_handshake  = 1'b1;
        w_state_next = (r_row == IDX_W'(N - 1)) ? IDLE : FETCH;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: coefficient latch, row fetch, column counter, result register.
  // The RAM address is updated only when a FETCH is entered, so it holds
  // its last value everywhere else.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_coef       <= '0;
      r_row_buf    <= '0;
      r_row        <= '0;
      r_j          <= '0;
      r_ri_address <= '0;
      r_out_data   <= '0;
      r_out_row    <= '0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_coef       <= coef;
        r_row        <= '0;
        r_ri_address <= '0;
      end
      if (r_state == FETCH) begin
        r_row_buf <= r_data;
        r_j       <= '0;
      end
      if (r_state == MAC)
        r_j <= r_j + 1'b1;
      if (w_mac_last) begin
        r_out_data  <= scale_out(w_acc_next, FRAC);
        r_out_row   <= r_row;
        r_out_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_out_valid <= 1'b0;
        if (r_row == IDX_W'(N - 1)) begin
          r_done <= 1'b1;
        end else begin
          r_row        <= r_row + 1'b1;
          r_ri_address <= r_row + 1'b1;
        end
      end
    end
  end

  assign ri_address = r_ri_address;
  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_row_dot_engine.sv
// Self-checking bench for row_dot_engine: constant-table passes, randomized
// passes against a plain-arithmetic reference model, and hand-written
// sequences for backpressure, ignored start and mid-pass reset.
module tb_row_dot_engine;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         out_ready;
  logic [127:0] coef;
  logic [2:0]   ri_address;
  logic [127:0] r_data;
  logic [15:0]  out_data;
  logic [2:0]   out_row;
  logic         out_valid;
  logic         busy;
  logic         done;

  logic [127:0] ram [8];
  logic [127:0] cvec;
  logic [15:0]  res_d [$];
  logic [2:0]   res_r [$];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] c;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
  } vec_t;
  vec_t tbl [8];

  row_dot_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .coef       (coef),
    .ri_address (ri_address),
    .r_data     (r_data),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  // Combinational row-read RAM model.
  assign r_data = ram[ri_address];

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum of signed products, floor-shift by 8, then wrap or clamp.
  function automatic logic [15:0] model_row(input int r);
    longint sum;
    longint sh;
    logic [127:0] rw;
    rw  = ram[r];
    sum = 0;
    for (int j = 0; j < 8; j++)
      sum += longint'($signed(rw[16*j +: 16])) * longint'($signed(cvec[16*j +: 16]));
    sh = sum >>> 8;
`ifdef ROW_DOT_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  function automatic logic [127:0] splat(input logic [15:0] w);
    return {8{w}};
  endfunction

  // One pass. mode 0: ready high; 1: random ready; 2: 5-cycle stall on row 3;
  // 3: ready high, coef disturbed and start re-pulsed during the pass.
  // Called mid-cycle (1 time unit after an edge).
  task automatic run_pass(input int mode, input int exp_done, input string tag);
    int          cyc;
    int          first_valid;
    int          done_cyc;
    int          stall;
    logic        holding;
    logic [15:0] held_d;
    logic [2:0]  held_r;
    res_d.delete();
    res_r.delete();
    coef  = cvec;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"}, busy, 1);
    check({tag, "_done_low_c1"}, done, 0);
    check({tag, "_addr_c1"}, ri_address, 0);
    first_valid = -1;
    done_cyc    = -1;
    stall       = 0;
    holding     = 1'b0;
    held_d      = '0;
    held_r      = '0;
    while (cyc < 2000) begin
      if (mode == 3 && cyc == 3) coef = ~cvec;
      if (mode == 3 && cyc == 5) start = 1'b1;
      if (mode == 3 && cyc == 6) start = 1'b0;
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(out_valid && out_row == 3'd3 && stall < 5);
        default: out_ready = 1'b1;
      endcase
      if (holding) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"}, out_data, held_d);
        check({tag, "_hold_row"}, out_row, held_r);
      end
      if (done) begin
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_valid_at_done"}, out_valid, 0);
        break;
      end
      holding = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (out_ready) begin
          res_d.push_back(out_data);
          res_r.push_back(out_row);
          $display("%s row %0d data %h cycle %0d", tag, out_row, out_data, cyc);
        end else begin
          holding = 1'b1;
          held_d  = out_data;
          held_r  = out_row;
          if (mode == 2) begin
            stall++;
            check({tag, "_stall_addr"}, ri_address, 3);
          end
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, (done_cyc > 0), 1);
    check({tag, "_first_valid"}, first_valid, 10);
    if (exp_done > 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_count"}, res_d.size(), 8);
    for (int k = 0; k < 8 && k < res_d.size(); k++) begin
      check({tag, "_row_idx"}, res_r[k], k);
      check({tag, "_row_data"}, res_d[k], model_row(k));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 16'h0800, 16'h0800};
    tbl[1] = '{16'hFF00, 16'h0100, 16'hF800, 16'hF800};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'hF800, 16'h7FFF};
    tbl[3] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000};
    tbl[4] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
    tbl[5] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{16'h8000, 16'h7FFF, 16'h0400, 16'h8000};
    tbl[7] = '{16'h0003, 16'h00AB, 16'h0010, 16'h0010};

    // Reset held with start high: everything must stay at zero.
    reset_n   = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    coef      = {4{$urandom}};
    for (int r = 0; r < 8; r++) ram[r] = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_addr", ri_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_busy", busy, 0);

    // Table passes: uniform rows and coefficients, ready tied high.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 8; r++) ram[r] = splat(tbl[t].word);
      cvec = splat(tbl[t].c);
      run_pass(0, 81, $sformatf("tbl%0d", t));
      for (int k = 0; k < 8 && k < res_d.size(); k++)
`ifdef ROW_DOT_SAT_EN
        check($sformatf("tbl%0d_const", t), res_d[k], tbl[t].exp_sat);
`else
        check($sformatf("tbl%0d_const", t), res_d[k], tbl[t].exp_wrap);
`endif
    end

    // Randomized passes with random backpressure.
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 8; r++)
        ram[r] = (p[0]) ? {$urandom, $urandom, $urandom, $urandom}
                        : {8{16'($urandom_range(0, 1023) - 512)}} ^ {4{$urandom & 32'h00FF_00FF}};
      cvec = {$urandom, $urandom, $urandom, $urandom};
      run_pass(1, -1, $sformatf("rnd%0d", p));
    end

    // Five-cycle stall on row 3: done moves from 81 to 86.
    for (int r = 0; r < 8; r++) ram[r] = {$urandom, $urandom, $urandom, $urandom};
    cvec = {$urandom, $urandom, $urandom, $urandom};
    run_pass(2, 86, "stall");

    // start re-pulsed during MAC and coef changed after acceptance: no effect.
    run_pass(3, 81, "ignore");

    // Reset during row-2 MAC aborts the pass.
    coef  = cvec;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (23) @(posedge clock);
    #1;
    check("mid_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_busy_after", busy, 0);
    check("mid_valid_after", out_valid, 0);
    check("mid_addr_after", ri_address, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset while a result is held valid: out_valid drops without a clock.
    out_ready = 1'b0;
    coef      = cvec;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int w = 0; w < 40 && !out_valid; w++) begin
      @(posedge clock); #1;
    end
    check("hold_valid_seen", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid_drop", out_valid, 0);
    check("async_data_clear", out_data, 0);
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;

    // Next start after an abort restarts from row 0.
    run_pass(0, 81, "restart");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/row_dot_engine.md
# row_dot_engine

Downstream consumer of the 8x8 matrix RAM (16-bit words) that computes one fixed-point dot product per row. On `start` it walks rows 0..7, reads each full 8-word row over the RAM row-read port, multiplies it element-wise by a latched 8-entry coefficient vector, accumulates, and emits one scaled 16-bit result per row over a valid/ready output. Typical use is matrix x vector after the RAM has been filled.

## Interface
- `WIDTH`, 16: word width; only 16 is supported.
- `N`, 8: row length and row count; only 8 is supported.
- `FRAC`, 8: fractional bits; the result is the accumulator arithmetically shifted right by `FRAC`.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a pass; sampled only in IDLE.
- `coef` in 128: signed coefficients; c_j in bits [16j+15:16j]; latched on the accepted `start`.
- `ri_address` out 3: row address to the RAM.
- `r_data` in 128: row from the RAM; word j in bits [16j+15:16j], signed.
- `out_data` out 16: scaled dot-product result.
- `out_row` out 3: row index of `out_data`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the row-7 handshake.

## Operation
- FSM states:
  - IDLE: `start` latches `coef`, sets row=0, and moves to FETCH.
  - FETCH: 1 cycle; `ri_address`=row; `r_data` is captured into row_buf at the end of the cycle. Then MAC with j=0 and acc=0.
  - MAC: 8 cycles; acc += row_buf[j]*c_j (16x16 signed -> 32 bits) with j++; after j=7, the scaled result is registered and the FSM moves to OUT.
  - OUT: `out_valid`=1 and holds until `out_ready`. On handshake:
    - row<7: row++ and go to FETCH.
    - row=7: go to IDLE and pulse `done`.
- Accumulator is 35-bit signed (8 x 32-bit terms with no overflow).
- Scaling: shifted = acc >>> FRAC (truncation toward minus infinity). Output conversion is set by the macro in Configuration.
- `start` in any state except IDLE is ignored. `coef` changes after acceptance are ignored.
- `out_data` and `out_row` are stable while `out_valid`=1 and `out_ready`=0.
- `ri_address` holds its last value outside FETCH. The RAM must not be written during a pass; written data is undefined for the current pass.
- Reset values: state IDLE, row=0, and `ri_address`, `out_data`, `out_row`, `out_valid`, `busy`, `done` all 0.
- Reset mid-pass aborts immediately: `out_valid` drops asynchronously and partial results are discarded. The next `start` restarts at row 0.

## Timing
- Start accepted at edge t0 -> FETCH in cycle 1 -> MAC in cycles 2..9 -> `out_valid` from cycle 10.
- Per-row minimum is 10 cycles (FETCH 1 + MAC 8 + OUT 1).
- With `out_ready` tied high, a full pass is 80 cycles. `done`=1 in cycle 81, and `busy` is 0 in that same cycle.
- Each cycle of backpressure adds exactly one cycle. No bubble exists between the OUT handshake and the next FETCH.
- `start` in the `done` cycle is accepted (the FSM is in IDLE).

## Configuration
- `ROW_DOT_SAT_EN` defined: shifted is clamped to [-32768, 32767].
- `ROW_DOT_SAT_EN` not defined: `out_data` = shifted[15:0] (two's-complement wrap).
- Nothing else differs.

## Structure
- Shared package `row_dot_pkg`:
  - WIDTH/N/FRAC defaults and ACC_W=35.
  - FSM state enum (IDLE, FETCH, MAC, OUT).
  - Helper function for shift-and-convert.
- One sub-module, `mac16`: 16x16 signed multiply plus 35-bit accumulate, with clear and enable inputs. The FSM, counters and output register stay in `row_dot_engine`.

## Test plan
- Reset with `reset_n`=0 and `start`=1 -> all outputs 0, `busy`=0, no `done`.
- All RAM words 0x0100, all coef 0x0100, `out_ready`=1 -> eight results 0x0800 with `out_row` 0..7; `out_valid` first at cycle 10; `done` at cycle 81.
- Row words 0xFF00, coef 0x0100 -> every `out_data` is 0xF800.
- All words and coef 0x7FFF -> 0x7FFF with `ROW_DOT_SAT_EN`; 0xF800 without it.
- `out_ready` low for 5 cycles on row 3 -> `out_data`/`out_row` stable, no new FETCH, `done` at cycle 86.
- `start` pulsed during MAC -> ignored. `reset_n` low during row-2 MAC -> `out_valid`=0 at once; the next `start` yields `out_row`=0 first.
